// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: round-robin edge-event scheduler with holdoff gap; define EDGE_TS_EN for per-channel edge timestamps on O_evtTs
module edge_event_arbiter #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 3,
    parameter int GAP   = 2
`ifdef EDGE_TS_EN
    ,
    parameter int TS_W  = 16
`endif
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic [N_CH-1:0]         I_sig,
    input  logic [N_CH-1:0]         I_chEn,
    input  logic [N_CH-1:0]         I_ovfClr,
    output logic                    O_evtVld,
    output logic [$clog2(N_CH)-1:0] O_evtCh,
    input  logic                    I_evtRdy,
    output logic [N_CH-1:0]         O_pend,
    output logic [N_CH-1:0]         O_ovf,
    output logic                    O_busy
`ifdef EDGE_TS_EN
    ,
    output logic [TS_W-1:0]         O_evtTs
`endif
);
    localparam int CHW = $clog2(N_CH);
    localparam int GW  = GAP > 1 ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_VLD, S_GAP} state_t;

    state_t           state, nxt;
    logic [N_CH-1:0]  lastSig, edgeDet, req, take, inc, dec, setOvf;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [CHW-1:0]   ptr, win;
    logic [GW-1:0]    gapCnt;
    logic             anyReq, xfer, grant;
    int               j;

    assign edgeDet = I_sig & ~lastSig & I_chEn;
    assign req     = O_pend & I_chEn;
    assign anyReq  = |req;
    assign xfer    = O_evtVld & I_evtRdy;
    assign grant   = state == S_IDLE && anyReq;

    // an edge and a consume in the same cycle cancel, so neither saturates nor underflows
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            take[c]   = xfer && O_evtCh == CHW'(c);
            inc[c]    = edgeDet[c] & ~take[c] & ~(&cnt[c]);
            dec[c]    = take[c] & ~edgeDet[c];
            setOvf[c] = edgeDet[c] & ~take[c] & (&cnt[c]);
            O_pend[c] = |cnt[c];
        end
    end

    // later iterations overwrite earlier ones, so the lowest offset from ptr wins
    always_comb begin
        win = '0;
        j   = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_CH;
            if (req[CHW'(j)]) win = CHW'(j);
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n)
        if (!I_rst_n) state <= S_IDLE;
        else state <= nxt;

    always_comb
        nxt = state == S_IDLE ? (anyReq ? S_VLD : S_IDLE)
            : state == S_VLD  ? (I_evtRdy ? (GAP == 0 ? S_IDLE : S_GAP) : S_VLD)
            : (gapCnt == '0 ? S_IDLE : S_GAP);

    always_comb begin
        O_evtVld = state == S_VLD;
        O_busy   = state != S_IDLE;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lastSig <= '0;
            O_ovf   <= '0;
            O_evtCh <= '0;
            ptr     <= '0;
            gapCnt  <= '0;
            for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
        end else begin
            lastSig <= I_sig;
            O_ovf   <= setOvf | (O_ovf & ~I_ovfClr);
            for (int c = 0; c < N_CH; c++) cnt[c] <= cnt[c] + CNT_W'(inc[c]) - CNT_W'(dec[c]);
            if (grant) O_evtCh <= win;
            if (xfer) ptr <= O_evtCh == CHW'(N_CH - 1) ? '0 : O_evtCh + 1'b1;
            gapCnt  <= xfer ? GW'(GAP - 1) : state == S_GAP ? gapCnt - 1'b1 : gapCnt;
        end
    end

`ifdef EDGE_TS_EN
    logic [TS_W-1:0] tsCnt;
    logic [TS_W-1:0] tsLat [N_CH];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            tsCnt   <= '0;
            O_evtTs <= '0;
            for (int c = 0; c < N_CH; c++) tsLat[c] <= '0;
        end else begin
            tsCnt <= tsCnt + 1'b1;
            for (int c = 0; c < N_CH; c++) if (edgeDet[c]) tsLat[c] <= tsCnt;
            if (grant) O_evtTs <= tsLat[win];
        end
    end
`endif
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed checks of edge counting, round-robin grants, saturation, masking and async reset
module tb_edge_event_arbiter;
    logic       I_clk = 1'b0;
    logic       I_rst_n;
    logic [3:0] I_sig, I_chEn, I_ovfClr;
    logic       I_evtRdy;
    logic       O_evtVld;
    logic [1:0] O_evtCh;
    logic [3:0] O_pend, O_ovf;
    logic       O_busy;
`ifdef EDGE_TS_EN
    logic [15:0] O_evtTs;
`endif
    int nErr = 0;
    int nChk = 0;
    int seen;

    edge_event_arbiter dut (
        .I_clk(I_clk),
        .I_rst_n(I_rst_n),
        .I_sig(I_sig),
        .I_chEn(I_chEn),
        .I_ovfClr(I_ovfClr),
        .O_evtVld(O_evtVld),
        .O_evtCh(O_evtCh),
        .I_evtRdy(I_evtRdy),
        .O_pend(O_pend),
        .O_ovf(O_ovf),
`ifdef EDGE_TS_EN
        .O_evtTs(O_evtTs),
`endif
        .O_busy(O_busy)
    );

    always #5 I_clk = ~I_clk;

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        I_sig    = '0;
        I_ovfClr = '0;
        I_chEn   = 4'hF;
        I_rst_n  = 1'b0;
        tick();
        tick();
        I_rst_n  = 1'b1;
    endtask

    initial begin
        I_evtRdy = 1'b1;
        resetDut();
        chk("rst_vld", 32'(O_evtVld), 0);
        chk("rst_busy", 32'(O_busy), 0);
        chk("rst_pend", 32'(O_pend), 0);
        chk("rst_ovf", 32'(O_ovf), 0);
        chk("rst_ch", 32'(O_evtCh), 0);

        // single pulse on ch2
        I_sig[2] = 1'b1;
        tick();
        chk("sp_pend", 32'(O_pend), 4'b0100);
        chk("sp_vld0", 32'(O_evtVld), 0);
        tick();
        chk("sp_vld1", 32'(O_evtVld), 1);
        chk("sp_ch", 32'(O_evtCh), 2);
        tick();
        chk("sp_vlddrop", 32'(O_evtVld), 0);
        chk("sp_pendclr", 32'(O_pend), 0);
        chk("sp_gapbusy", 32'(O_busy), 1);
        tick();
        tick();
        chk("sp_idle", 32'(O_busy), 0);

        // round robin across all four channels
        resetDut();
        I_sig = 4'hF;
        tick();
        chk("rr_pend", 32'(O_pend), 4'hF);
        tick();
        for (int g = 0; g < 4; g++) begin
            chk("rr_vld", 32'(O_evtVld), 1);
            chk("rr_ch", 32'(O_evtCh), 32'(g));
            tick();
            chk("rr_drop", 32'(O_evtVld), 0);
            tick();
            tick();
            tick();
        end
        chk("rr_pendend", 32'(O_pend), 0);

        // backpressure and saturation on ch1
        resetDut();
        I_evtRdy = 1'b0;
        for (int p = 0; p < 9; p++) begin
            I_sig[1] = 1'b1;
            tick();
            I_sig[1] = 1'b0;
            tick();
        end
        chk("bp_ovf", 32'(O_ovf), 4'b0010);
        chk("bp_pend", 32'(O_pend), 4'b0010);
        chk("bp_vld", 32'(O_evtVld), 1);
        chk("bp_ch", 32'(O_evtCh), 1);
        I_sig[1] = 1'b1;
        I_ovfClr[1] = 1'b1;
        tick();
        I_sig[1] = 1'b0;
        I_ovfClr[1] = 1'b0;
        chk("bp_setwins", 32'(O_ovf), 4'b0010);
        I_evtRdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (O_evtVld) seen++;
            tick();
        end
        chk("bp_events", 32'(seen), 7);
        chk("bp_drained", 32'(O_pend), 0);
        chk("bp_ovfheld", 32'(O_ovf), 4'b0010);
        I_ovfClr[1] = 1'b1;
        tick();
        I_ovfClr[1] = 1'b0;
        chk("bp_ovfclr", 32'(O_ovf), 0);

        // edge and consume in the same cycle on ch0
        resetDut();
        I_sig[0] = 1'b1;
        tick();
        I_sig[0] = 1'b0;
        tick();
        chk("ec_vld", 32'(O_evtVld), 1);
        chk("ec_ch", 32'(O_evtCh), 0);
        I_sig[0] = 1'b1;
        tick();
        I_sig[0] = 1'b0;
        chk("ec_cnt", 32'(O_pend), 4'b0001);
        chk("ec_drop", 32'(O_evtVld), 0);
        tick();
        tick();
        tick();
        chk("ec_vld2", 32'(O_evtVld), 1);
        chk("ec_ch2", 32'(O_evtCh), 0);
        tick();
        chk("ec_pend0", 32'(O_pend), 0);

        // masking ch3
        resetDut();
        I_chEn = 4'b0111;
        I_sig[3] = 1'b1;
        tick();
        tick();
        tick();
        chk("mk_pend", 32'(O_pend), 0);
        chk("mk_vld", 32'(O_evtVld), 0);
        I_chEn = 4'hF;
        tick();
        tick();
        chk("mk_noedge", 32'(O_pend), 0);
        I_sig[3] = 1'b0;
        tick();
        I_evtRdy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            I_sig[3] = 1'b1;
            tick();
            I_sig[3] = 1'b0;
            tick();
        end
        chk("mk_grant", 32'(O_evtCh), 3);
        I_chEn[3] = 1'b0;
        tick();
        tick();
        tick();
        chk("mk_held", 32'(O_pend), 4'b1000);
        chk("mk_vldheld", 32'(O_evtVld), 1);
        I_chEn = 4'hF;
        I_evtRdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (O_evtVld) seen++;
            tick();
        end
        chk("mk_events", 32'(seen), 2);
        chk("mk_drained", 32'(O_pend), 0);

        // asynchronous reset in the middle of S_VLD
        resetDut();
        I_evtRdy = 1'b0;
        for (int p = 0; p < 8; p++) begin
            I_sig[1] = 1'b1;
            tick();
            I_sig[1] = 1'b0;
            tick();
        end
        chk("ar_preovf", 32'(O_ovf), 4'b0010);
        chk("ar_prevld", 32'(O_evtVld), 1);
        #2;
        I_rst_n = 1'b0;
        #1;
        chk("ar_vld", 32'(O_evtVld), 0);
        chk("ar_pend", 32'(O_pend), 0);
        chk("ar_ovf", 32'(O_ovf), 0);
        chk("ar_busy", 32'(O_busy), 0);
        tick();
        I_rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event scheduler for the test-bed trigger path.
- Detects rising edges on N synchronous level inputs and keeps a saturating pending-event count per channel.
- Shares one downstream event consumer between the channels using round-robin arbitration and a valid/ready handshake.
- Inserts a programmable holdoff gap between consecutive grants.

Parameters:
- N_CH, 4, number of input channels (2..16).
- CNT_W, 3, width of each pending-event counter; saturates at 2^CNT_W-1.
- GAP, 2, idle cycles forced after each accepted event (0 = back-to-back).
- TS_W, 16, timestamp width (used only with EDGE_TS_EN).

Ports:
- I_clk  in  1  system clock; all logic on rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_sig  in  N_CH  level inputs, already synchronous to I_clk.
- I_chEn  in  N_CH  per-channel enable; a 0 masks edge counting and arbitration.
- I_ovfClr  in  N_CH  per-channel one-cycle clear of the overflow flag.
- O_evtVld  out  1  event valid to the consumer.
- O_evtCh  out  clog2(N_CH)  granted channel index.
- I_evtRdy  in  1  consumer ready; an event is transferred when O_evtVld & I_evtRdy.
- O_pend  out  N_CH  per-channel "count != 0".
- O_ovf  out  N_CH  sticky per-channel overflow flag.
- O_busy  out  1  high whenever the FSM is not in S_IDLE.
- O_evtTs  out  TS_W  timestamp of the granted event (EDGE_TS_EN only).

Behaviour:
- Reset, asynchronous assert: all sample registers, counters, O_ovf, O_evtVld, O_evtCh, O_busy, the round-robin pointer and the gap counter go to 0; FSM goes to S_IDLE. Deassert takes effect at the next I_clk edge.
- Edge detect: each channel registers its last sample (reset 0). edge[i] = I_sig[i] & ~last[i] & I_chEn[i]. A channel held high through reset gives one edge on the first cycle after reset.
- Counter update at each clock edge:
  - edge only: +1.
  - consume only (transfer on channel i): -1.
  - edge and consume together: count unchanged.
  - edge while count is at max: count stays at max and O_ovf[i] is set.
  - I_ovfClr[i] clears O_ovf[i]; if a set and a clear land in the same cycle, set wins.
- Masked channel (I_chEn[i]=0): count is retained but the channel is not arbitrated. Re-enabling resumes arbitration, with no spurious edge unless I_sig rises.
- FSM S_IDLE:
  - If any (count != 0 & I_chEn) exists, the winner is the first requesting channel searching upward from ptr, wrapping mod N_CH.
  - Register O_evtCh = winner, set O_evtVld = 1, go to S_VLD.
- FSM S_VLD:
  - O_evtVld and O_evtCh are held stable until the transfer; the grant is never withdrawn, even if the channel is masked meanwhile.
  - On I_evtRdy: decrement that channel's count, set ptr = (ch+1) mod N_CH, drop O_evtVld at the same edge.
  - Then go to S_GAP with the gap counter loaded to GAP-1, or to S_IDLE if GAP=0.
- FSM S_GAP: decrement the gap counter; at 0 go to S_IDLE. Edges are still counted during S_GAP.
- Latency: a rising edge sampled at clock edge k increments the count at k. With the FSM idle, O_evtVld rises after edge k+1.
- Throughput: one event per 2+GAP cycles at most (GAP=0 gives one event every 2 cycles).
- O_pend and O_ovf are registered outputs or direct functions of registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro EDGE_TS_EN.
- Defined:
  - A free-running TS_W-bit counter (reset 0, wraps) runs on I_clk.
  - Each channel latches the counter value on every accepted edge, including edges at saturation.
  - O_evtTs is loaded from the granted channel's latch when O_evtVld rises and is held through S_VLD; it gives the time of the latest edge on that channel.
- Undefined: no counter, no latches, and O_evtTs is absent from the port list.

Test Plan:
- Single pulse: I_sig[2] rises at cycle 10, I_evtRdy=1, GAP=2 -> O_evtVld=1, O_evtCh=2 after edge 11, high for exactly one cycle; O_pend[2] returns to 0.
- Round-robin: all 4 channels rise in the same cycle, I_evtRdy=1 -> grants in order 0,1,2,3, each 4 cycles apart (2+GAP).
- Backpressure and saturation: I_evtRdy=0, 9 pulses on ch1, CNT_W=3 -> count 7 and O_ovf[1]=1; O_evtCh held at 1. Then I_evtRdy=1 -> exactly 7 events delivered; I_ovfClr[1] clears the flag.
- Simultaneous edge and consume on ch0 with count 1 -> count stays 1 and a second event follows.
- Mask: I_chEn[3]=0 with a pulse on ch3 -> no count and no grant. Pre-loaded ch3 count of 2 is held while masked and both events are delivered after re-enable.
- Async reset: assert I_rst_n=0 mid-S_VLD -> O_evtVld=0, all counts 0 and O_ovf=0 immediately, without waiting for a clock edge. EDGE_TS_EN build: edge at ts=0x0005 -> O_evtTs=0x0005.
